// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : PC owner and single-outstanding imem fetch sequencer with
//            jump/branch redirect, wrong-path squash and IMEM-window halt.
//            Bound checking and HALT are enabled by FETCH_BOUND_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter logic [31:0] IMEM_START = 32'h0000_0000,
  parameter logic [31:0] IMEM_END   = 32'h0000_0064
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_jump,
  input  logic [31:0] jump_offset,
  input  logic        redirect_branch,
  input  logic [31:0] branch_offset,
  input  logic [31:0] redirect_base,
  input  logic        restart,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic [31:0] r_inst_pc, w_inst_pc_nxt;
  logic        r_inst_valid, w_inst_valid_nxt;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_consume;
  logic        w_pc_ok;
  logic        w_target_ok;
  logic        w_restart;

`ifdef FETCH_BOUND_CHECK_EN
  logic r_halted;

  // Offset-from-start compare keeps the window check a single unsigned test.
  assign w_pc_ok     = ((r_pc - IMEM_START) <= (IMEM_END - IMEM_START)) && (r_pc[1:0] == 2'b00);
  assign w_target_ok = ((w_target - IMEM_START) <= (IMEM_END - IMEM_START)) && (w_target[1:0] == 2'b00);
  assign w_restart   = restart && (r_state == S_HALT);
  assign halted      = r_halted;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_halted <= 1'b0;
    end else begin
      r_halted <= (w_state_nxt == S_HALT);
    end
  end
`else
  logic w_unused_restart;

  assign w_pc_ok          = 1'b1;
  assign w_target_ok      = 1'b1;
  assign w_restart        = 1'b0;
  assign w_unused_restart = restart;
  assign halted           = 1'b0;
`endif

  assign w_redirect = (redirect_jump || redirect_branch) && (r_state != S_IDLE);
  assign w_target   = redirect_base + (redirect_jump ? jump_offset : branch_offset);
  assign w_consume  = r_inst_valid && !stall;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_inst_nxt       = r_inst;
    w_inst_pc_nxt    = r_inst_pc;
    w_inst_valid_nxt = r_inst_valid;

    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          w_inst_nxt       = imem_rdata;
          w_inst_pc_nxt    = r_pc;
          w_inst_valid_nxt = 1'b1;
          w_pc_nxt         = r_pc + 32'd4;
          w_state_nxt      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_consume) begin
          w_inst_valid_nxt = 1'b0;
          w_state_nxt      = w_pc_ok ? S_REQ : S_HALT;
        end
      end
      S_HALT: begin
        if (w_consume) begin
          w_inst_valid_nxt = 1'b0;
        end
        if (w_restart) begin
          w_pc_nxt    = IMEM_START;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Redirect squashes any held or arriving instruction; restart outranks it.
    if (w_redirect && !w_restart) begin
      w_pc_nxt         = w_target;
      w_inst_valid_nxt = 1'b0;
      w_state_nxt      = w_target_ok ? S_REQ : S_HALT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= IMEM_START;
      r_inst       <= 32'd0;
      r_inst_pc    <= 32'd0;
      r_inst_valid <= 1'b0;
      r_imem_req   <= 1'b0;
      r_imem_addr  <= IMEM_START;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_imem_req   <= (w_state_nxt == S_REQ);
      r_imem_addr  <= w_pc_nxt;
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_imem_addr;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;

endmodule
`default_nettype wire
